// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the regFile writeback arbiter slice.
//   - Default data/address widths matching regFile.
//   - Requester index constants (ALU = 0, load unit = 1).
//   - wb_req_t: one writeback request bundle {valid, addr, data} at default widths.
package regfile_pkg;

    localparam int N_DEFAULT = 32;
    localparam int R_DEFAULT = 7;

    localparam int REQ_ALU   = 0;
    localparam int REQ_LOAD  = 1;

    typedef struct packed {
        logic                 valid;
        logic [R_DEFAULT-1:0] addr;
        logic [N_DEFAULT-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter.
//   Ports:
//     clk, rst  clock, asynchronous active-high reset
//     req[1:0]  request vector (bit REQ_ALU, bit REQ_LOAD)
//     advance   a grant was taken this cycle; rotate priority away from the winner
//     grant[1:0] one-hot grant (combinational, zero when no request)
//   The priority state names the requester that wins when both request.
//   It only moves on advance, so idle cycles keep the current priority.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    typedef enum logic {
        PRIO_ALU  = 1'b0,
        PRIO_LOAD = 1'b1
    } prio_e;

    prio_e state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PRIO_ALU;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        grant     = 2'b00;
        state_nxt = state;

        case (req)
            2'b01:   grant[REQ_ALU]  = 1'b1;
            2'b10:   grant[REQ_LOAD] = 1'b1;
            2'b11: begin
                if (state == PRIO_ALU) begin
                    grant[REQ_ALU] = 1'b1;
                end else begin
                    grant[REQ_LOAD] = 1'b1;
                end
            end
            default: grant = 2'b00;
        endcase

        // The winner goes to the back of the line.
        if (advance) begin
            state_nxt = grant[REQ_ALU] ? PRIO_LOAD : PRIO_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single regFile write port between the ALU (requester 0) and the
//   load unit (requester 1), and keeps a per-register busy scoreboard for decode.
//   Ports:
//     clk, rst                      clock, asynchronous active-high reset
//     wb0_valid/addr/data/ready     ALU writeback request and handshake
//     wb1_valid/addr/data/ready     load-unit writeback request and handshake
//     sb_reserve, sb_reserve_addr   decode marks a destination register busy
//     chk_addr1/2, chk_busy1/2      source register busy lookup (combinational)
//     reserve_conflict              sticky: a reserve hit an already-busy register
//     rf_regWrite/writeReg/writeData registered write command to regFile
//   Accepted writes are registered once and presented to regFile in the next
//   cycle; regFile commits on the posedge that ends that cycle, which is the
//   same edge that clears the register's busy bit.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int n = N_DEFAULT,
    parameter int r = R_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         wb0_valid,
    input  logic [r-1:0] wb0_addr,
    input  logic [n-1:0] wb0_data,
    output logic         wb0_ready,

    input  logic         wb1_valid,
    input  logic [r-1:0] wb1_addr,
    input  logic [n-1:0] wb1_data,
    output logic         wb1_ready,

    input  logic         sb_reserve,
    input  logic [r-1:0] sb_reserve_addr,
    input  logic [r-1:0] chk_addr1,
    input  logic [r-1:0] chk_addr2,
    output logic         chk_busy1,
    output logic         chk_busy2,
    output logic         reserve_conflict,

    output logic         rf_regWrite,
    output logic [r-1:0] rf_writeReg,
    output logic [n-1:0] rf_writeData
);

    localparam int NREG = 2**r;

    logic [1:0]   req;
    logic [1:0]   grant;
    logic         xfer_p0;
    logic [r-1:0] sel_addr_p0;
    logic [n-1:0] sel_data_p0;

    logic         wr_vld_p1;
    logic [r-1:0] wr_addr_p1;
    logic [n-1:0] wr_data_p1;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            conflict_hit;
    logic            conflict;

    // ---- stage p0: arbitration and request select ----
    assign req = {wb1_valid, wb0_valid};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (xfer_p0),
        .grant   (grant)
    );

    assign wb0_ready   = grant[REQ_ALU];
    assign wb1_ready   = grant[REQ_LOAD];
    assign xfer_p0     = |grant;
    assign sel_addr_p0 = grant[REQ_LOAD] ? wb1_addr : wb0_addr;
    assign sel_data_p0 = grant[REQ_LOAD] ? wb1_data : wb0_data;

    // ---- stage p1: registered write command to regFile ----
    // A transfer to r0 is still consumed, but never raises the write strobe.
    // Without a transfer the address/data simply hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_vld_p1 <= xfer_p0 && (sel_addr_p0 != '0);
            if (xfer_p0) begin
                wr_addr_p1 <= sel_addr_p0;
                wr_data_p1 <= sel_data_p0;
            end
        end
    end

    assign rf_regWrite  = wr_vld_p1;
    assign rf_writeReg  = wr_addr_p1;
    assign rf_writeData = wr_data_p1;

    // Scoreboard update: the clear from the write landing this edge is applied
    // first, so a reserve of the same register re-arms it (new pending write)
    // and does not count as a conflict.
    always_comb begin
        busy_nxt     = busy;
        conflict_hit = 1'b0;
        if (wr_vld_p1) begin
            busy_nxt[wr_addr_p1] = 1'b0;
        end
        if (sb_reserve && (sb_reserve_addr != '0)) begin
            conflict_hit              = busy_nxt[sb_reserve_addr];
            busy_nxt[sb_reserve_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            conflict <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            conflict <= conflict | conflict_hit;
        end
    end

    // busy[0] is never set, so r0 always reads as free.
    assign chk_busy1        = busy[chk_addr1];
    assign chk_busy2        = busy[chk_addr2];
    assign reserve_conflict = conflict;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed scenarios with literal expectations, then randomized traffic,
//   all compared every cycle against a behavioural model of the arbiter,
//   write register and scoreboard.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int N = 32;
    localparam int R = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wb0_valid = 1'b0, wb1_valid = 1'b0;
    logic [R-1:0] wb0_addr = '0, wb1_addr = '0;
    logic [N-1:0] wb0_data = '0, wb1_data = '0;
    logic         wb0_ready, wb1_ready;
    logic         sb_reserve = 1'b0;
    logic [R-1:0] sb_reserve_addr = '0;
    logic [R-1:0] chk_addr1 = '0, chk_addr2 = '0;
    logic         chk_busy1, chk_busy2, reserve_conflict;
    logic         rf_regWrite;
    logic [R-1:0] rf_writeReg;
    logic [N-1:0] rf_writeData;

    regfile_wb_arbiter #(.n(N), .r(R)) dut (
        .clk              (clk),
        .rst              (rst),
        .wb0_valid        (wb0_valid),
        .wb0_addr         (wb0_addr),
        .wb0_data         (wb0_data),
        .wb0_ready        (wb0_ready),
        .wb1_valid        (wb1_valid),
        .wb1_addr         (wb1_addr),
        .wb1_data         (wb1_data),
        .wb1_ready        (wb1_ready),
        .sb_reserve       (sb_reserve),
        .sb_reserve_addr  (sb_reserve_addr),
        .chk_addr1        (chk_addr1),
        .chk_addr2        (chk_addr2),
        .chk_busy1        (chk_busy1),
        .chk_busy2        (chk_busy2),
        .reserve_conflict (reserve_conflict),
        .rf_regWrite      (rf_regWrite),
        .rf_writeReg      (rf_writeReg),
        .rf_writeData     (rf_writeData)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int           m_prio;       // requester that wins a tie
    int           m_g;          // requester granted this cycle, -1 for none
    bit           m_we;         // regFile write expected this cycle
    logic [R-1:0] m_wreg;
    logic [N-1:0] m_wdata;
    bit           m_busy [2**R];
    bit           m_conf;
    bit           m_acc0, m_acc1;

    wb_req_t q0, q1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prio  = 0;
        m_g     = -1;
        m_we    = 1'b0;
        m_wreg  = '0;
        m_wdata = '0;
        m_conf  = 1'b0;
        m_acc0  = 1'b0;
        m_acc1  = 1'b0;
        for (int i = 0; i < 2**R; i++) m_busy[i] = 1'b0;
    endtask

    // Compare every observable output with the model (called mid-cycle).
    task automatic compare_all();
        int g;
        g = -1;
        if (wb0_valid && wb1_valid) g = m_prio;
        else if (wb0_valid)         g = 0;
        else if (wb1_valid)         g = 1;
        m_g = g;
        chk("m_wb0_ready", 64'(wb0_ready), 64'(g == 0));
        chk("m_wb1_ready", 64'(wb1_ready), 64'(g == 1));
        chk("m_rf_regWrite", 64'(rf_regWrite), 64'(m_we));
        if (m_we) begin
            chk("m_rf_writeReg", 64'(rf_writeReg), 64'(m_wreg));
            chk("m_rf_writeData", 64'(rf_writeData), 64'(m_wdata));
        end
        chk("m_chk_busy1", 64'(chk_busy1), 64'(m_busy[chk_addr1]));
        chk("m_chk_busy2", 64'(chk_busy2), 64'(m_busy[chk_addr2]));
        chk("m_reserve_conflict", 64'(reserve_conflict), 64'(m_conf));
    endtask

    // Advance the model across one clock edge using the inputs seen this cycle.
    task automatic model_update();
        logic [R-1:0] a;
        a = sb_reserve_addr;
        if (sb_reserve && a != '0) begin
            if (m_busy[a] && !(m_we && m_wreg == a)) m_conf = 1'b1;
        end
        if (m_we) m_busy[m_wreg] = 1'b0;
        if (sb_reserve && a != '0) m_busy[a] = 1'b1;
        if (m_g >= 0) begin
            m_wreg  = (m_g == 0) ? wb0_addr : wb1_addr;
            m_wdata = (m_g == 0) ? wb0_data : wb1_data;
            m_we    = (m_wreg != '0);
            m_prio  = 1 - m_g;
        end else begin
            m_we = 1'b0;
        end
        m_acc0 = (m_g == 0);
        m_acc1 = (m_g == 1);
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Assert reset mid-cycle, check outputs clear immediately, release just after an edge.
    task automatic mid_reset();
        #2;
        rst        = 1'b1;
        wb0_valid  = 1'b0;
        wb1_valid  = 1'b0;
        sb_reserve = 1'b0;
        #1;
        chk("rst_rf_regWrite", 64'(rf_regWrite), 64'(0));
        chk("rst_rf_writeReg", 64'(rf_writeReg), 64'(0));
        chk("rst_rf_writeData", 64'(rf_writeData), 64'(0));
        chk("rst_reserve_conflict", 64'(reserve_conflict), 64'(0));
        for (int i = 0; i < 16; i++) begin
            chk_addr1 = 7'(i);
            chk_addr2 = 7'(i + 16);
            #1;
            chk("rst_busy1", 64'(chk_busy1), 64'(0));
            chk("rst_busy2", 64'(chk_busy2), 64'(0));
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        mid_reset();

        // After reset: lone ALU request is granted
        wb0_valid = 1'b1; wb0_addr = 7'd5; wb0_data = 32'hDEADBEEF;
        #1;
        chk("post_rst_wb0_ready", 64'(wb0_ready), 64'(1));
        chk("post_rst_wb1_ready", 64'(wb1_ready), 64'(0));
        step();
        chk("single_we", 64'(rf_regWrite), 64'(1));
        chk("single_reg", 64'(rf_writeReg), 64'(5));
        chk("single_data", 64'(rf_writeData), 64'(32'hDEADBEEF));
        wb0_valid = 1'b0;
        step();
        chk("single_we_after", 64'(rf_regWrite), 64'(0));

        // Reset while a write is registered but not yet committed
        wb0_valid = 1'b1; wb0_addr = 7'd7; wb0_data = 32'h1234;
        step();
        chk("pre_reset_we", 64'(rf_regWrite), 64'(1));
        mid_reset();

        // Contention: grants alternate 0,1,0,1, every write appears once
        wb0_valid = 1'b1; wb0_addr = 7'd3; wb0_data = 32'hA3A3A3A3;
        wb1_valid = 1'b1; wb1_addr = 7'd4; wb1_data = 32'hB4B4B4B4;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_wb0_ready", 64'(wb0_ready), 64'(i % 2 == 0));
            chk("cont_wb1_ready", 64'(wb1_ready), 64'(i % 2 == 1));
            step();
            chk("cont_we", 64'(rf_regWrite), 64'(1));
            chk("cont_reg", 64'(rf_writeReg), (i % 2 == 0) ? 64'd3 : 64'd4);
            chk("cont_data", 64'(rf_writeData), (i % 2 == 0) ? 64'hA3A3A3A3 : 64'hB4B4B4B4);
        end
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        step();
        chk("cont_no_dup", 64'(rf_regWrite), 64'(0));

        // Scoreboard: reserve 9, then load unit writes 9
        sb_reserve = 1'b1; sb_reserve_addr = 7'd9; chk_addr1 = 7'd9; chk_addr2 = 7'd0;
        #1;
        chk("sb_no_bypass", 64'(chk_busy1), 64'(0));
        step();
        sb_reserve = 1'b0;
        #1;
        chk("sb_busy_set", 64'(chk_busy1), 64'(1));
        wb1_valid = 1'b1; wb1_addr = 7'd9; wb1_data = 32'h99;
        #1;
        chk("sb_wb1_ready", 64'(wb1_ready), 64'(1));
        step();
        wb1_valid = 1'b0;
        chk("sb_busy_issue", 64'(chk_busy1), 64'(1));
        chk("sb_issue_reg", 64'(rf_writeReg), 64'(9));
        step();
        chk("sb_busy_cleared", 64'(chk_busy1), 64'(0));
        chk("sb_r0_free", 64'(chk_busy2), 64'(0));

        // Set/clear collision on one edge
        sb_reserve = 1'b1; sb_reserve_addr = 7'd9;
        step();
        sb_reserve = 1'b0;
        wb0_valid = 1'b1; wb0_addr = 7'd9; wb0_data = 32'h55;
        step();
        wb0_valid = 1'b0;
        chk("coll_we", 64'(rf_regWrite), 64'(1));
        sb_reserve = 1'b1; sb_reserve_addr = 7'd9;
        step();
        sb_reserve = 1'b0;
        #1;
        chk("coll_busy", 64'(chk_busy1), 64'(1));
        chk("coll_no_conflict", 64'(reserve_conflict), 64'(0));

        // r0 write, then double reserve
        wb0_valid = 1'b1; wb0_addr = 7'd0; wb0_data = 32'hFFFF;
        #1;
        chk("r0_ready", 64'(wb0_ready), 64'(1));
        step();
        wb0_valid = 1'b0;
        chk("r0_no_write", 64'(rf_regWrite), 64'(0));
        sb_reserve = 1'b1; sb_reserve_addr = 7'd12;
        step();
        chk("res12_first", 64'(reserve_conflict), 64'(0));
        step();
        sb_reserve = 1'b0;
        chk("res12_second", 64'(reserve_conflict), 64'(1));
        step();
        step();
        chk("res12_sticky", 64'(reserve_conflict), 64'(1));

        // Randomized traffic
        mid_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 500 == 499) mid_reset();
            if (!(wb0_valid && !m_acc0)) begin
                q0.valid = ($urandom % 3) != 0;
                q0.addr  = 7'($urandom_range(0, 15));
                q0.data  = $urandom;
                wb0_valid = q0.valid; wb0_addr = q0.addr; wb0_data = q0.data;
            end
            if (!(wb1_valid && !m_acc1)) begin
                q1.valid = ($urandom % 3) != 0;
                q1.addr  = 7'($urandom_range(0, 15));
                q1.data  = $urandom;
                wb1_valid = q1.valid; wb1_addr = q1.addr; wb1_data = q1.data;
            end
            sb_reserve      = ($urandom % 4) == 0;
            sb_reserve_addr = 7'($urandom_range(0, 15));
            chk_addr1       = 7'($urandom_range(0, 15));
            chk_addr2       = 7'($urandom_range(0, 15));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
